// File: rtl/csr_unit.sv
// Machine-mode CSR file and interrupt controller for the Execute stage.
// Latency: reads and redirect are combinational, writes commit at the next edge; no backpressure.
module csr_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_E,
    input  logic [31:0] PC_E,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        is_mret,
    input  logic        timer_intr,
    input  logic        ext_intr,
    output logic [31:0] csr_rdata,
    output logic [31:0] epc,
    output logic        epc_taken,
    output logic        trap_kill
);

    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0880;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mip_q, mip_d;
    logic [63:0] mcycle_q, mcycle_d;

    logic        pend;
    logic        mret_go;
    logic        csr_we;
    logic [31:0] cause;
    logic [31:0] tvec_base;
    logic [31:0] wval;
    logic [63:0] mcycle_inc;

    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = mstatus_q;
            12'h304: csr_rdata = mie_q;
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h344: csr_rdata = mip_q;
            12'hB00: csr_rdata = mcycle_q[31:0];
            12'hB80: csr_rdata = mcycle_q[63:32];
            default: csr_rdata = 32'h0;
        endcase
    end

    // External outranks timer when both are enabled and pending.
    assign pend      = mstatus_q[3] & valid_E & (|(mip_q & mie_q));
    assign cause     = (mip_q[11] & mie_q[11]) ? 32'd11 : 32'd7;
    assign tvec_base = mtvec_q & ~32'h3;
    assign mret_go   = is_mret & valid_E & ~pend;
    assign csr_we    = valid_E & (|csr_op) & ~pend;
    assign trap_kill = pend;
    assign epc_taken = pend | (is_mret & valid_E);

    always_comb begin
        epc = mepc_q;
        if (pend) begin
            case (mtvec_q[1:0])
                2'b00:   epc = tvec_base;
                2'b01:   epc = tvec_base + (cause << 2);
                default: epc = mepc_q;
            endcase
        end
    end

    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    assign mcycle_inc = mcycle_q + 64'd1;

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mip_d      = {20'h0, ext_intr, 3'b000, timer_intr, 7'h00};
        mcycle_d   = mcycle_inc;

        if (csr_we) begin
            case (csr_addr)
                12'h300: mstatus_d  = wval & MSTATUS_MASK;
                12'h304: mie_d      = wval & MIE_MASK;
                12'h305: mtvec_d    = wval & ~32'h2;
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = wval & ~32'h3;
                12'h342: mcause_d   = wval;
                // The unwritten half still takes the increment, including carry.
                12'hB00: mcycle_d[31:0]  = wval;
                12'hB80: mcycle_d[63:32] = wval;
                default: ;
            endcase
        end

        if (pend) begin
            mepc_d    = PC_E & ~32'h3;
            mcause_d  = {1'b1, cause[30:0]};
            mstatus_d = {24'h0, mstatus_q[3], 7'h00};
        end else if (mret_go) begin
            mstatus_d = {24'h0, 1'b1, 3'b000, mstatus_q[7], 3'b000};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= 32'h0;
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RST & ~32'h2;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mip_q      <= 32'h0;
            mcycle_q   <= 64'h0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mip_q      <= mip_d;
            mcycle_q   <= mcycle_d;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios then random traffic against a reference model.
module tb_csr_unit;

    localparam logic [31:0] TB_MTVEC_RST = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_E;
    logic [31:0] PC_E;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        is_mret;
    logic        timer_intr;
    logic        ext_intr;
    logic [31:0] csr_rdata;
    logic [31:0] epc;
    logic        epc_taken;
    logic        trap_kill;

    csr_unit #(.MTVEC_RST(TB_MTVEC_RST)) dut (
        .clk(clk), .rst(rst), .valid_E(valid_E), .PC_E(PC_E),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .is_mret(is_mret), .timer_intr(timer_intr), .ext_intr(ext_intr),
        .csr_rdata(csr_rdata), .epc(epc), .epc_taken(epc_taken), .trap_kill(trap_kill)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference architectural state
    logic [31:0] m_ms, m_mie, m_tvec, m_scr, m_epc, m_cause, m_mip;
    logic [63:0] m_cyc;

    logic [31:0] obs_rd, obs_epc;
    logic        obs_taken, obs_kill;
    bit          ti, ei;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ms = 0; m_mie = 0; m_tvec = TB_MTVEC_RST & ~32'h2;
        m_scr = 0; m_epc = 0; m_cause = 0; m_mip = 0; m_cyc = 0;
    endtask

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return m_ms;
            12'h304: return m_mie;
            12'h305: return m_tvec;
            12'h340: return m_scr;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h344: return m_mip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        logic [31:0] e_rd, e_epc, base, w;
        logic [63:0] nc;
        bit          e_pend, e_taken;
        int unsigned cause;
        @(negedge clk);
        e_rd   = mread(csr_addr);
        e_pend = m_ms[3] && valid_E && ((m_mip & m_mie) != 0);
        cause  = (m_mip[11] && m_mie[11]) ? 11 : 7;
        base   = m_tvec & ~32'h3;
        if (e_pend && m_tvec[1:0] == 2'b00)      e_epc = base;
        else if (e_pend && m_tvec[1:0] == 2'b01) e_epc = base + 4 * cause;
        else                                      e_epc = m_epc;
        e_taken = e_pend || (is_mret && valid_E);
        obs_rd = csr_rdata; obs_epc = epc; obs_taken = epc_taken; obs_kill = trap_kill;
        chk("csr_rdata", csr_rdata, e_rd);
        chk("epc", epc, e_epc);
        chk("epc_taken", {31'h0, epc_taken}, {31'h0, e_taken});
        chk("trap_kill", {31'h0, trap_kill}, {31'h0, e_pend});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            nc = m_cyc + 64'd1;
            if (e_pend) begin
                m_epc   = PC_E & ~32'h3;
                m_cause = 32'h8000_0000 | cause;
                m_ms    = m_ms[3] ? 32'h80 : 32'h0;
            end else begin
                if (valid_E && csr_op != 2'b00) begin
                    if (csr_op == 2'b01)      w = csr_wdata;
                    else if (csr_op == 2'b10) w = e_rd | csr_wdata;
                    else                      w = e_rd & ~csr_wdata;
                    case (csr_addr)
                        12'h300: m_ms    = w & 32'h88;
                        12'h304: m_mie   = w & 32'h880;
                        12'h305: m_tvec  = w & ~32'h2;
                        12'h340: m_scr   = w;
                        12'h341: m_epc   = w & ~32'h3;
                        12'h342: m_cause = w;
                        12'hB00: nc[31:0]  = w;
                        12'hB80: nc[63:32] = w;
                        default: ;
                    endcase
                end
                if (is_mret && valid_E) m_ms = 32'h80 | (m_ms[7] ? 32'h8 : 32'h0);
            end
            m_cyc = nc;
            m_mip = (ext_intr ? 32'h800 : 32'h0) | (timer_intr ? 32'h80 : 32'h0);
        end
        #1;
    endtask

    task automatic cyc(input bit v, input logic [31:0] pc, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] wd, input bit mret, input bit r);
        valid_E = v; PC_E = pc; csr_op = op; csr_addr = a; csr_wdata = wd;
        is_mret = mret; timer_intr = ti; ext_intr = ei; rst = r;
        step();
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        cyc(1'b1, 32'h1000, op, a, wd, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [11:0] a);
        cyc(1'b1, 32'h1000, 2'b00, a, 32'h0, 1'b0, 1'b0);
    endtask

    logic [11:0] addrs [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h344, 12'hB00, 12'hB80, 12'h301, 12'h7C0, 12'hF14};

    initial begin
        logic [31:0] prev;
        logic [1:0]  op;
        ti = 0; ei = 0;
        rst = 1; valid_E = 0; PC_E = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        is_mret = 0; timer_intr = 0; ext_intr = 0;
        @(posedge clk); #1;
        model_reset();

        // Reset state and free-running counter
        rd(12'h300); chk("rst_mstatus", obs_rd, 32'h0);
        chk("rst_taken", {31'h0, obs_taken}, 32'h0);
        chk("rst_epc", obs_epc, 32'h0);
        rd(12'h305); chk("rst_mtvec", obs_rd, TB_MTVEC_RST);
        rd(12'hB00); prev = obs_rd;
        rd(12'hB00); chk("mcycle_inc", obs_rd, prev + 32'd1);

        // Read-modify-write ops on mscratch
        csr_wr(2'b01, 12'h340, 32'hDEAD_BEEF); chk("rw_old", obs_rd, 32'h0);
        csr_wr(2'b10, 12'h340, 32'h0000_00F0); chk("rs_old", obs_rd, 32'hDEAD_BEEF);
        csr_wr(2'b11, 12'h340, 32'h0000_00FF); chk("rc_old", obs_rd, 32'hDEAD_BEFF);
        rd(12'h340); chk("rc_new", obs_rd, 32'hDEAD_BE00);

        // Direct-mode timer trap
        csr_wr(2'b01, 12'h305, 32'h100);
        csr_wr(2'b01, 12'h304, 32'h80);
        csr_wr(2'b01, 12'h300, 32'h8);
        ti = 1;
        cyc(1'b0, 32'h3C, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0);
        chk("bubble_no_kill", {31'h0, obs_kill}, 32'h0);
        cyc(1'b1, 32'h40, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0);
        chk("dtrap_taken", {31'h0, obs_taken}, 32'h1);
        chk("dtrap_kill", {31'h0, obs_kill}, 32'h1);
        chk("dtrap_epc", obs_epc, 32'h100);
        ti = 0;
        rd(12'h341); chk("dtrap_mepc", obs_rd, 32'h40);
        rd(12'h342); chk("dtrap_mcause", obs_rd, 32'h8000_0007);
        rd(12'h300); chk("dtrap_mstatus", obs_rd, 32'h80);

        // MRET
        cyc(1'b1, 32'h104, 2'b00, 12'h0, 32'h0, 1'b1, 1'b0);
        chk("mret_taken", {31'h0, obs_taken}, 32'h1);
        chk("mret_epc", obs_epc, 32'h40);
        chk("mret_kill", {31'h0, obs_kill}, 32'h0);
        rd(12'h300); chk("mret_mstatus", obs_rd, 32'h88);

        // Vectored trap, both sources, colliding CSRRW squashed
        csr_wr(2'b01, 12'h305, 32'h201);
        csr_wr(2'b01, 12'h304, 32'h880);
        ti = 1; ei = 1;
        cyc(1'b0, 32'h7C, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h80, 2'b01, 12'h340, 32'h1234_5678, 1'b0, 1'b0);
        chk("vtrap_epc", obs_epc, 32'h22C);
        chk("vtrap_kill", {31'h0, obs_kill}, 32'h1);
        ti = 0; ei = 0;
        rd(12'h340); chk("vtrap_no_write", obs_rd, 32'hDEAD_BE00);
        rd(12'h342); chk("vtrap_mcause", obs_rd, 32'h8000_000B);

        // Bubbles hold off a pending interrupt; reset on the trapping cycle wins
        cyc(1'b1, 32'h22C, 2'b00, 12'h0, 32'h0, 1'b1, 1'b0);
        ti = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h300, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0);
            chk("bubble_hold", {31'h0, obs_kill}, 32'h0);
        end
        cyc(1'b1, 32'h300, 2'b00, 12'h0, 32'h0, 1'b0, 1'b1);
        chk("rst_cycle_kill", {31'h0, obs_kill}, 32'h1);
        ti = 0;
        rd(12'h341); chk("rst_mepc", obs_rd, 32'h0);
        rd(12'h305); chk("rst2_mtvec", obs_rd, TB_MTVEC_RST);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) ti = ~ti;
            if ($urandom_range(0, 7) == 0) ei = ~ei;
            op = 2'($urandom_range(0, 3));
            cyc($urandom_range(0, 3) != 0, $urandom & ~32'h3, op,
                addrs[$urandom_range(0, 11)], $urandom,
                (op == 2'b00) && ($urandom_range(0, 5) == 0),
                $urandom_range(0, 149) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
